// File: rtl/alu_pkg.sv
// Shared opcode constants, arbiter state encoding and response bundle for the
// shared-ALU arbiter and its datapath.
package alu_pkg;

  localparam logic [2:0] ALU_PASS_B   = 3'b000;
  localparam logic [2:0] ALU_ADD      = 3'b010;
  localparam logic [2:0] ALU_SUBTRACT = 3'b011;
  localparam logic [2:0] ALU_AND      = 3'b100;
  localparam logic [2:0] ALU_OR       = 3'b101;
  localparam logic [2:0] ALU_XOR      = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [63:0] result;
    logic        negative;
    logic        zero;
    logic        overflow;
    logic        carry_out;
    logic        err;
  } alu_rsp_t;

  // 001 and 111 are unassigned opcodes.
  function automatic logic is_legal_op(input logic [2:0] op);
    return (op != 3'b001) && (op != 3'b111);
  endfunction

endpackage

// File: rtl/alu.sv
// 64-bit combinational ALU: pass, add, subtract and bitwise ops with flags.
// Overflow and carry are only meaningful for ADD/SUB and read 0 otherwise.
module alu
  import alu_pkg::*;
(
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic [2:0]  cntrl_i,
  output logic [63:0] result_o,
  output logic        negative_o,
  output logic        zero_o,
  output logic        overflow_o,
  output logic        carry_out_o
);

  logic [64:0] add_w;
  logic [64:0] sub_w;

  assign add_w = {1'b0, a_i} + {1'b0, b_i};
  // Subtract as A + ~B + 1 so the carry out is the inverted borrow.
  assign sub_w = {1'b0, a_i} + {1'b0, ~b_i} + 65'd1;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    result_o    = '0;
    overflow_o  = 1'b0;
    carry_out_o = 1'b0;
    case (cntrl_i)
      ALU_PASS_B: result_o = b_i;
      ALU_ADD: begin
        result_o    = add_w[63:0];
        carry_out_o = add_w[64];
        overflow_o  = (a_i[63] == b_i[63]) && (add_w[63] != a_i[63]);
      end
      ALU_SUBTRACT: begin
        result_o    = sub_w[63:0];
        carry_out_o = sub_w[64];
        overflow_o  = (a_i[63] != b_i[63]) && (sub_w[63] != a_i[63]);
      end
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_XOR: result_o = a_i ^ b_i;
      default: result_o = '0;
    endcase
  end

  assign negative_o = result_o[63];
  assign zero_o     = (result_o == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NREQ requesters; one operation in
// flight, IDLE -> EXEC -> RESP, with a registered one-hot tagged response.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0][63:0] req_a,
  input  logic [NREQ-1:0][63:0] req_b,
  input  logic [NREQ-1:0][2:0]  req_cntrl,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [63:0]           rsp_result,
  output logic                  rsp_negative,
  output logic                  rsp_zero,
  output logic                  rsp_overflow,
  output logic                  rsp_carry_out,
  output logic                  rsp_err
);

  localparam int SW = IDW + 1;

  arb_state_t     state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] owner_q;
  logic [IDW-1:0] grant_idx;
  logic           grant_vld;
  logic [SW-1:0]  cand;
  logic           accept;

  logic [63:0]    a_q, b_q;
  logic [2:0]     cntrl_q;
  alu_rsp_t       rsp_q;

  logic [63:0]    alu_result;
  logic           alu_negative, alu_zero, alu_overflow, alu_carry_out;

  // Scan downward so the lowest offset from rr_ptr wins the final assignment.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_q} + SW'(k);
      if (cand >= SW'(NREQ)) cand = cand - SW'(NREQ);
      if (req_valid[cand[IDW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[IDW-1:0];
      end
    end
  end

  assign accept = (state_q == IDLE) && grant_vld;

  // Gated by reset_n so no request is acknowledged while reset is held.
  always_comb begin
    req_ready = '0;
    if (reset_n && accept) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == RESP) rsp_valid[owner_q] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: if (grant_vld) begin
        state_d  = EXEC;
        rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
      end
      EXEC: state_d = RESP;
      RESP: if (rsp_ready[owner_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: operand registers carry no reset; they are always loaded on accept
  // before the ALU output they feed is captured, so reset would only add fanout.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q     <= req_a[grant_idx];
      b_q     <= req_b[grant_idx];
      cntrl_q <= req_cntrl[grant_idx];
    end
  end

  alu u_alu (
    .a_i         (a_q),
    .b_i         (b_q),
    .cntrl_i     (cntrl_q),
    .result_o    (alu_result),
    .negative_o  (alu_negative),
    .zero_o      (alu_zero),
    .overflow_o  (alu_overflow),
    .carry_out_o (alu_carry_out)
  );

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      rsp_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      if (accept) owner_q <= grant_idx;
      if (state_q == EXEC) begin
        if (is_legal_op(cntrl_q)) begin
          rsp_q.result    <= alu_result;
          rsp_q.negative  <= alu_negative;
          rsp_q.zero      <= alu_zero;
          rsp_q.overflow  <= alu_overflow;
          rsp_q.carry_out <= alu_carry_out;
          rsp_q.err       <= 1'b0;
        end else begin
          rsp_q.result    <= '0;
          rsp_q.negative  <= 1'b0;
          rsp_q.zero      <= 1'b1;
          rsp_q.overflow  <= 1'b0;
          rsp_q.carry_out <= 1'b0;
          rsp_q.err       <= 1'b1;
        end
      end
    end
  end

  assign rsp_result    = rsp_q.result;
  assign rsp_negative  = rsp_q.negative;
  assign rsp_zero      = rsp_q.zero;
  assign rsp_overflow  = rsp_q.overflow;
  assign rsp_carry_out = rsp_q.carry_out;
  assign rsp_err       = rsp_q.err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with two requesters.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NREQ = 2;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NREQ-1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ-1:0][63:0] req_a, req_b;
  logic [NREQ-1:0][2:0]  req_cntrl;
  logic [63:0]           rsp_result;
  logic                  rsp_negative, rsp_zero, rsp_overflow, rsp_carry_out, rsp_err;
  logic [4:0]            flags;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign flags = {rsp_negative, rsp_zero, rsp_overflow, rsp_carry_out, rsp_err};

  alu_arbiter #(.NREQ(NREQ)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_cntrl     (req_cntrl),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_negative  (rsp_negative),
    .rsp_zero      (rsp_zero),
    .rsp_overflow  (rsp_overflow),
    .rsp_carry_out (rsp_carry_out),
    .rsp_err       (rsp_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Issues one op on requester idx from IDLE and checks the full response.
  // Flags are {negative, zero, overflow, carry_out, err}; rsp_ready must be high.
  task automatic run_op(input int idx, input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] op, input logic [63:0] exp_res,
                        input logic [4:0] exp_flags);
    logic [NREQ-1:0] oh;
    int waited;
    oh = NREQ'(1) << idx;
    req_a[idx]     = a;
    req_b[idx]     = b;
    req_cntrl[idx] = op;
    req_valid[idx] = 1'b1;
    #1;
    waited = 0;
    while (req_ready !== oh && waited < 8) begin
      @(posedge clk);
      #3;
      waited++;
    end
    check($sformatf("grant r%0d op%b", idx, op), 64'(req_ready), 64'(oh));
    @(posedge clk);
    #2;
    req_valid[idx] = 1'b0;
    check($sformatf("exec quiet op%b", op), 64'({rsp_valid, req_ready}), 64'd0);
    step();
    check($sformatf("rsp_valid op%b", op), 64'(rsp_valid), 64'(oh));
    check($sformatf("result op%b", op), rsp_result, exp_res);
    check($sformatf("flags op%b", op), 64'(flags), 64'(exp_flags));
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cntrl = '0;
    rsp_ready = '0;

    // Reset state, with requests present to show ready is suppressed.
    #12;
    req_valid = '1;
    #1;
    check("reset req_ready", 64'(req_ready), 64'd0);
    check("reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset result", rsp_result, 64'd0);
    check("reset flags", 64'(flags), 64'd0);
    req_valid = '0;
    @(posedge clk);
    #2;
    reset_n   = 1'b1;
    rsp_ready = '1;
    step();
    check("idle no request", 64'({rsp_valid, req_ready}), 64'd0);

    run_op(0, 64'd1, 64'd1, ALU_ADD, 64'd2, 5'b00000);
    run_op(1, 64'd2, 64'd3, ALU_SUBTRACT, 64'hFFFF_FFFF_FFFF_FFFF, 5'b10000);

    // Contention: both held valid, grants alternate 0,1,0,1.
    req_a[0] = 64'd10;   req_b[0] = 64'd5;    req_cntrl[0] = ALU_ADD;
    req_a[1] = 64'hF0;   req_b[1] = 64'h0F;   req_cntrl[1] = ALU_XOR;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("contention grant %0d", i), 64'(req_ready),
            (i % 2 == 0) ? 64'd1 : 64'd2);
      @(posedge clk);
      #2;
      check($sformatf("contention exec %0d", i), 64'(rsp_valid), 64'd0);
      step();
      check($sformatf("contention tag %0d", i), 64'(rsp_valid),
            (i % 2 == 0) ? 64'd1 : 64'd2);
      check($sformatf("contention result %0d", i), rsp_result,
            (i % 2 == 0) ? 64'd15 : 64'hFF);
      check($sformatf("contention flags %0d", i), 64'(flags), 64'd0);
      step();
    end
    req_valid = '0;

    // Backpressure: response held while rsp_ready is low or foreign.
    rsp_ready = 2'b00;
    req_a[0] = 64'h7FFF_FFFF_FFFF_FFFF; req_b[0] = 64'd2; req_cntrl[0] = ALU_ADD;
    req_valid = 2'b01;
    #1;
    check("bp grant", 64'(req_ready), 64'd1);
    @(posedge clk);
    #2;
    req_a[1] = 64'd9; req_b[1] = 64'd9; req_cntrl[1] = ALU_OR;
    req_valid = 2'b10;
    step();
    for (int i = 0; i < 6; i++) begin
      check($sformatf("bp valid %0d", i), 64'(rsp_valid), 64'd1);
      check($sformatf("bp result %0d", i), rsp_result, 64'h8000_0000_0000_0001);
      check($sformatf("bp flags %0d", i), 64'(flags), 64'(5'b10100));
      check($sformatf("bp req_ready %0d", i), 64'(req_ready), 64'd0);
      if (i == 4) rsp_ready = 2'b10;
      step();
    end
    req_valid = '0;
    rsp_ready = 2'b11;
    step();
    check("bp released", 64'(rsp_valid), 64'd0);

    // Illegal opcodes bypass the ALU; following legal ops are unaffected.
    run_op(0, 64'd5, 64'd5, 3'b111, 64'd0, 5'b01001);
    run_op(1, 64'd7, 64'd3, ALU_AND, 64'd3, 5'b00000);
    run_op(0, 64'd1, 64'd1, 3'b001, 64'd0, 5'b01001);
    run_op(1, 64'd5, 64'd9, ALU_PASS_B, 64'd9, 5'b00000);
    run_op(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, ALU_ADD, 64'd0, 5'b01010);
    run_op(0, 64'd5, 64'd3, ALU_SUBTRACT, 64'd2, 5'b00010);

    // Async reset while in EXEC: operation dropped, pointer back to 0.
    req_a[0] = 64'd3; req_b[0] = 64'd4; req_cntrl[0] = ALU_ADD;
    req_a[1] = 64'd100; req_b[1] = 64'd1; req_cntrl[1] = ALU_ADD;
    req_valid = 2'b01;
    #1;
    check("rst grant", 64'(req_ready), 64'd1);
    @(posedge clk);
    #2;
    req_valid = 2'b11;
    check("rst exec", 64'(rsp_valid), 64'd0);
    #3;
    reset_n = 1'b0;
    #1;
    check("rst rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst req_ready", 64'(req_ready), 64'd0);
    check("rst result", rsp_result, 64'd0);
    check("rst flags", 64'(flags), 64'd0);
    req_valid = '0;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst no response %0d", i), 64'(rsp_valid), 64'd0);
    end
    req_valid = 2'b11;
    #1;
    check("rst next grant", 64'(req_ready), 64'd1);
    @(posedge clk);
    #2;
    req_valid = '0;
    step();
    check("rst next tag", 64'(rsp_valid), 64'd1);
    check("rst next result", rsp_result, 64'd7);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one 64-bit combinational `alu` among `NREQ` requesters, such as a fetch/branch unit and the execute stage, through valid/ready handshakes. Each requester submits one operation (A, B, cntrl) and receives the registered result and flags (negative, zero, overflow, carry_out) on a shared response bus. Access is granted round-robin. Exactly one operation is in flight at a time.

## Interface
Parameters:
- `NREQ`, 2: number of requesters; legal range 2..4.
- `IDW`, $clog2(NREQ): width of the requester index.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset_n` input 1: reset, asynchronous and active-low.
- `req_valid` input [NREQ-1:0]: requester i presents an operation.
- `req_ready` output [NREQ-1:0]: operation of requester i accepted this cycle.
- `req_a`, `req_b` input [NREQ-1:0][63:0]: operands per requester.
- `req_cntrl` input [NREQ-1:0][2:0]: ALU opcode per requester.
- `rsp_valid` output [NREQ-1:0]: one-hot; response belongs to requester i.
- `rsp_ready` input [NREQ-1:0]: requester i consumes the response.
- `rsp_result` output 64: registered ALU result.
- `rsp_negative`, `rsp_zero`, `rsp_overflow`, `rsp_carry_out` output 1 each: registered flags.
- `rsp_err` output 1: opcode was illegal (001 or 111).

## Operation
- Opcodes:
  - 000 PASS_B.
  - 010 ADD.
  - 011 SUB (A-B, carry_out = NOT borrow).
  - 100 AND.
  - 101 OR.
  - 110 XOR.
- FSM states:
  - IDLE: accepts requests.
  - EXEC: ALU evaluates the latched operands.
  - RESP: response held.
- IDLE:
  - Grant goes to the first i with `req_valid[i]`, searching from `rr_ptr` upward with wrap.
  - `req_ready[grant]` = 1 combinationally; all other ready bits are 0.
  - On handshake, latch a, b, cntrl and the owner id; `rr_ptr` <= grant+1 mod NREQ; go to EXEC.
- EXEC: capture the ALU outputs into the response registers; go to RESP.
- Flag rules:
  - `rsp_overflow` and `rsp_carry_out` are forced to 0 for non-ADD/SUB opcodes.
  - `rsp_negative` = result[63]; `rsp_zero` = (result == 0).
- Illegal opcode:
  - ALU bypassed: result 0, zero=1, all other flags 0, `rsp_err`=1.
  - Still occupies a full EXEC/RESP cycle.
- RESP:
  - `rsp_valid[owner]` = 1; data is stable until the handshake.
  - On `rsp_ready[owner]`, go to IDLE. Ready bits of other requesters are ignored.
- With no valid request, remain in IDLE; `rr_ptr` is unchanged.
- Requesters must hold `req_*` stable while `req_valid`=1 and `req_ready`=0.

## Timing
- Reset (async assert, sync deassert by the system):
  - state = IDLE, `rr_ptr` = 0.
  - All `rsp_*` = 0; `req_ready` = 0 only while in reset.
- Latency: request handshake in cycle k leads to `rsp_valid` high in cycle k+2.
- Minimum turnaround is 3 cycles per operation: the RESP handshake is followed by IDLE, where a new grant occurs the same cycle.
- `req_ready` is asserted only in IDLE; never in EXEC or RESP.
- Simultaneous requests: exactly one grant per IDLE cycle; no requester waits more than NREQ-1 grants.
- Reset mid-operation: the in-flight operation is dropped with no response; `rr_ptr` returns to 0.
- A requester whose `req_valid` drops before grant is skipped without penalty.

## Structure
- Shared package `alu_pkg`:
  - opcode constants ALU_PASS_B, ALU_ADD, ALU_SUBTRACT, ALU_AND, ALU_OR, ALU_XOR.
  - state enum `arb_state_t` {IDLE, EXEC, RESP}.
  - `is_legal_op()` function.
- One natural sub-module: the existing `alu`, instantiated once and fed from the latched operand registers.
- Round-robin grant logic stays inline in `alu_arbiter`.

## Test plan
- Single ADD:
  - Stimulus: req0 A=1, B=1, cntrl=010; `rsp_ready` held high.
  - Response: `rsp_valid`=01 two cycles after accept; result=2; all flags 0.
- SUB borrow:
  - Stimulus: req1 A=2, B=3, cntrl=011.
  - Response: `rsp_valid`=10; result=FFFF_FFFF_FFFF_FFFF; negative=1; carry_out=0; overflow=0.
- Contention, NREQ=2:
  - Stimulus: both requesters valid continuously.
  - Response: grant order 0,1,0,1; each response is tagged to the correct one-hot bit.
- Backpressure:
  - Stimulus: `rsp_ready`=0 for 5 cycles after a 0x7FFF_FFFF_FFFF_FFFF + 2 request.
  - Response: result 0x8000_0000_0000_0001 and overflow=1 held stable; `req_ready` stays 0 throughout.
- Illegal opcode:
  - Stimulus: cntrl=111.
  - Response: result=0; zero=1; `rsp_err`=1; the next legal operation is processed normally.
- Async reset in EXEC:
  - Stimulus: pull `reset_n` low mid-cycle.
  - Response: all outputs go to 0 immediately; no response is issued after release; the next grant goes to requester 0.
